// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler that shares one 4x4 tensor core between NUM_REQ requesters.
// Optional WAIT-state abort on a stuck core: define TENSOR_CORE_TIMEOUT_EN.
module tensor_core_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = $clog2(NUM_REQ),
  localparam int MAT_W         = 16 * DATA_WIDTH
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MAT_W-1:0] req_a,
  input  logic [NUM_REQ*MAT_W-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [MAT_W-1:0]         resp_c,
  output logic                     resp_error,
  output logic [MAT_W-1:0]         core_input1,
  output logic [MAT_W-1:0]         core_input2,
  output logic                     core_write_enable,
  output logic                     core_start,
  input  logic [MAT_W-1:0]         core_result,
  input  logic                     core_done,
  output logic                     busy,
  output logic [15:0]              jobs_completed
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   job_id;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  int                idx;

`ifdef TENSOR_CORE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  wait_cnt;
  logic              timed_out;
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign resp_error = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Search starts at rr_ptr and wraps, so the last-served requester goes to the back of the line.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state        = state;
    req_ready         = '0;
    core_write_enable = 1'b0;
    core_start        = 1'b0;
    resp_valid        = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready  = NUM_REQ'(1) << grant_idx;
          next_state = LOAD;
        end
      end
      LOAD: begin
        core_write_enable = 1'b1;
        next_state        = START;
      end
      START: begin
        core_start = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (core_done) next_state = RESP;
`ifdef TENSOR_CORE_TIMEOUT_EN
        else if (timed_out) next_state = RESP;
`endif
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The core operand registers double as the job registers: loaded on accept, held through WAIT.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      rr_ptr         <= '0;
      job_id         <= '0;
      core_input1    <= '0;
      core_input2    <= '0;
      resp_c         <= '0;
      resp_id        <= '0;
      jobs_completed <= '0;
`ifdef TENSOR_CORE_TIMEOUT_EN
      resp_error     <= 1'b0;
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            job_id      <= grant_idx;
            core_input1 <= req_a[grant_idx*MAT_W +: MAT_W];
            core_input2 <= req_b[grant_idx*MAT_W +: MAT_W];
          end
        end
        START: begin
`ifdef TENSOR_CORE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            resp_c  <= core_result;
            resp_id <= job_id;
`ifdef TENSOR_CORE_TIMEOUT_EN
            resp_error <= 1'b0;
          end else if (timed_out) begin
            resp_c     <= '0;
            resp_id    <= job_id;
            resp_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            if (job_id == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                              rr_ptr <= job_id + 1'b1;
            jobs_completed <= jobs_completed + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Self-checking bench for tensor_core_scheduler with a behavioural tensor core and job-level reference model.
// Timeout scenario runs only when TENSOR_CORE_TIMEOUT_EN is defined.
module tb_tensor_core_scheduler;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int MW = 16 * DW;
  localparam int TO = 8;

  logic              clock_in = 1'b0;
  logic              reset_n_in;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*MW-1:0]   req_a, req_b;
  logic              resp_valid, resp_ready;
  logic [0:0]        resp_id;
  logic [MW-1:0]     resp_c;
  logic              resp_error;
  logic [MW-1:0]     core_input1, core_input2, core_result;
  logic              core_write_enable, core_start, core_done;
  logic              busy;
  logic [15:0]       jobs_completed;

  int vectors = 0;
  int miscompares = 0;
  int model_rr = 0;
  int model_jobs = 0;

  logic [MW-1:0] core_pending;
  int            core_cnt;
  bit            core_stuck = 1'b0;

  tensor_core_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_c(resp_c), .resp_error(resp_error),
    .core_input1(core_input1), .core_input2(core_input2),
    .core_write_enable(core_write_enable), .core_start(core_start),
    .core_result(core_result), .core_done(core_done),
    .busy(busy), .jobs_completed(jobs_completed)
  );

  always #5 clock_in = ~clock_in;

  // Reference 4x4 signed matmul, each element truncated to DW bits.
  function automatic logic [MW-1:0] ref_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] r;
    int s, av, bv;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          av = $signed(a[(i*4+k)*DW +: DW]);
          bv = $signed(b[(k*4+j)*DW +: DW]);
          s += av * bv;
        end
        r[(i*4+j)*DW +: DW] = s[DW-1:0];
      end
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] r;
    for (int w = 0; w < MW/32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Behavioural core: latency 1..5 after start, done sticky until the next write-enable.
  always @(posedge clock_in) begin
    if (!reset_n_in) begin
      core_done   <= 1'b0;
      core_result <= '0;
      core_cnt    <= 0;
    end else begin
      if (core_write_enable) core_done <= 1'b0;
      if (core_start) begin
        core_pending <= ref_mul(core_input1, core_input2);
        core_cnt     <= $urandom_range(1, 5);
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1 && !core_stuck) begin
          core_done   <= 1'b1;
          core_result <= core_pending;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    reset_n_in = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    core_stuck = 1'b0;
    req_a      = {rand_mat(), rand_mat()};
    req_b      = {rand_mat(), rand_mat()};
    tick();
    tick();
    reset_n_in = 1'b1;
    model_rr   = 0;
    model_jobs = 0;
  endtask

  task automatic submit(input int r, input logic [MW-1:0] a, input logic [MW-1:0] b, output bit ok);
    req_a[r*MW +: MW] = a;
    req_b[r*MW +: MW] = b;
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (req_ready[r] === 1'b1) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid[r] = 1'b0;
    req_a[r*MW +: MW] = rand_mat();
    req_b[r*MW +: MW] = rand_mat();
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (resp_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++; if (resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_error: got %b want 0", resp_error); end
    vectors++; if (resp_id !== '0) begin miscompares++; $display("[TB] FAIL reset_resp_id: got %h want 0", resp_id); end
    vectors++; if (resp_c !== '0) begin miscompares++; $display("[TB] FAIL reset_resp_c: got %h want 0", resp_c); end
    vectors++; if (core_input1 !== '0) begin miscompares++; $display("[TB] FAIL reset_core_input1: got %h want 0", core_input1); end
    vectors++; if (core_input2 !== '0) begin miscompares++; $display("[TB] FAIL reset_core_input2: got %h want 0", core_input2); end
    vectors++; if (core_write_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_core_we: got %b want 0", core_write_enable); end
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_core_start: got %b want 0", core_start); end
    vectors++; if (jobs_completed !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_jobs: got %0d want 0", jobs_completed); end
    tick();
  endtask

  task automatic test_identity();
    logic [MW-1:0] a, b;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[(i*4+j)*DW +: DW] = (i == j) ? 8'd1 : 8'd0;
        b[(i*4+j)*DW +: DW] = 8'(4*i + j);
      end
    submit(0, a, b, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL t1_accept: got no req_ready want accept"); end
    #1;
    vectors++; if (core_write_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL t1_load_we: got %b want 1", core_write_enable); end
    vectors++; if (core_input1 !== a) begin miscompares++; $display("[TB] FAIL t1_core_in1: got %h want %h", core_input1, a); end
    vectors++; if (core_input2 !== b) begin miscompares++; $display("[TB] FAIL t1_core_in2: got %h want %h", core_input2, b); end
    tick();
    #1;
    vectors++; if (core_start !== 1'b1 || core_write_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL t1_start: got start=%b we=%b want 1/0", core_start, core_write_enable); end
    tick();
    wait_resp(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL t1_resp_timeout: got no resp_valid want resp"); end
    vectors++; if (resp_c !== b) begin miscompares++; $display("[TB] FAIL t1_resp_c: got %h want %h", resp_c, b); end
    vectors++; if (resp_id !== 1'b0 || resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL t1_id_err: got %b/%b want 0/0", resp_id, resp_error); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    vectors++; if (jobs_completed !== 16'd1) begin miscompares++; $display("[TB] FAIL t1_jobs: got %0d want 1", jobs_completed); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL t1_idle: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_arith();
    logic [MW-1:0] a, b, e;
    int r;
    bit ok;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      if (j == 0) begin a = {16{8'd2}};  b = {16{8'd3}};  e = {16{8'd24}}; r = 0; end
      else if (j == 1) begin a = {16{8'd16}}; b = {16{8'd16}}; e = '0; r = 0; end
      else begin a = rand_mat(); b = rand_mat(); e = ref_mul(a, b); r = $urandom_range(0, N-1); end
      submit(r, a, b, ok);
      wait_resp(ok);
      vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL t2_resp_timeout job%0d: got no resp want resp", j); end
      vectors++; if (resp_c !== e) begin miscompares++; $display("[TB] FAIL t2_resp_c job%0d: got %h want %h", j, resp_c, e); end
      vectors++; if (resp_id !== 1'(r) || resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL t2_id_err job%0d: got %0d/%b want %0d/0", j, resp_id, resp_error, r); end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
      vectors++; if (jobs_completed !== 16'(j + 1)) begin miscompares++; $display("[TB] FAIL t2_jobs: got %0d want %0d", jobs_completed, j + 1); end
      tick();
    end
  endtask

  task automatic test_fairness();
    int done_cnt;
    int exp_id_q[$];
    logic [MW-1:0] exp_c_q[$];
    logic [N-1:0] one;
    int g;
    one = 1;
    do_reset();
    done_cnt = 0;
    for (int t = 0; t < 200 && done_cnt < 4; t++) begin
      req_valid  = '1;
      req_a      = {rand_mat(), rand_mat()};
      req_b      = {rand_mat(), rand_mat()};
      resp_ready = 1'b1;
      #1;
      vectors++; if ($countones(req_ready) > 1) begin miscompares++; $display("[TB] FAIL t3_ready_onehot: got %b want at most one", req_ready); end
      if (req_ready !== '0) begin
        g = rr_pick(req_valid, model_rr);
        vectors++; if (req_ready !== (one << g)) begin miscompares++; $display("[TB] FAIL t3_grant: got %b want %b", req_ready, one << g); end
        exp_id_q.push_back(g);
        exp_c_q.push_back(ref_mul(req_a[g*MW +: MW], req_b[g*MW +: MW]));
      end
      if (resp_valid === 1'b1 && exp_id_q.size() > 0) begin
        vectors++; if (resp_id !== 1'(done_cnt % 2)) begin miscompares++; $display("[TB] FAIL t3_id_seq: got %0d want %0d", resp_id, done_cnt % 2); end
        vectors++; if (resp_c !== exp_c_q[0]) begin miscompares++; $display("[TB] FAIL t3_resp_c: got %h want %h", resp_c, exp_c_q[0]); end
        model_rr = (exp_id_q[0] + 1) % N;
        void'(exp_id_q.pop_front());
        void'(exp_c_q.pop_front());
        done_cnt++;
      end
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
    vectors++; if (done_cnt != 4 || jobs_completed !== 16'd4) begin miscompares++; $display("[TB] FAIL t3_count: got %0d/%0d want 4/4", done_cnt, jobs_completed); end
    tick();
  endtask

  task automatic test_stall();
    logic [MW-1:0] a, b, a0, b0;
    bit ok;
    do_reset();
    a = rand_mat(); b = rand_mat();
    a0 = rand_mat(); b0 = rand_mat();
    submit(1, a, b, ok);
    wait_resp(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL t4_resp_timeout: got no resp want resp"); end
    tick();
    req_a[0 +: MW] = a0; req_b[0 +: MW] = b0;
    req_valid = '1;
    for (int t = 0; t < 10; t++) begin
      #1;
      vectors++; if (resp_valid !== 1'b1 || resp_id !== 1'b1) begin miscompares++; $display("[TB] FAIL t4_hold_valid_id cyc%0d: got %b/%0d want 1/1", t, resp_valid, resp_id); end
      vectors++; if (resp_c !== ref_mul(a, b)) begin miscompares++; $display("[TB] FAIL t4_hold_c cyc%0d: got %h want %h", t, resp_c, ref_mul(a, b)); end
      vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL t4_no_ready cyc%0d: got %b want 0", t, req_ready); end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL t4_bubble: got %b want 0", req_ready); end
    tick();
    resp_ready = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL t4_next_grant: got %b want 01", req_ready); end
    vectors++; if (jobs_completed !== 16'd1) begin miscompares++; $display("[TB] FAIL t4_jobs: got %0d want 1", jobs_completed); end
    tick();
    req_valid = '0;
    wait_resp(ok);
    vectors++; if (!ok || resp_id !== 1'b0 || resp_c !== ref_mul(a0, b0)) begin miscompares++; $display("[TB] FAIL t4_second: got ok=%b id=%0d c=%h want 1/0/%h", ok, resp_id, resp_c, ref_mul(a0, b0)); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    bit outstanding, started, armed;
    int g;
    int exp_id_q[$];
    logic [MW-1:0] exp_c_q[$];
    logic [N-1:0] one, exp_ready;
    one = 1;
    do_reset();
    outstanding = 0; started = 0; armed = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid  = N'($urandom_range(0, (1 << N) - 1));
      req_a      = {rand_mat(), rand_mat()};
      req_b      = {rand_mat(), rand_mat()};
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = outstanding ? -1 : rr_pick(req_valid, model_rr);
      exp_ready = (g >= 0) ? (one << g) : '0;
      vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rnd_ready cyc%0d: got %b want %b", cyc, req_ready, exp_ready); end
      vectors++; if (busy !== outstanding) begin miscompares++; $display("[TB] FAIL rnd_busy cyc%0d: got %b want %b", cyc, busy, outstanding); end
      vectors++; if (resp_valid !== (outstanding && armed)) begin miscompares++; $display("[TB] FAIL rnd_resp_valid cyc%0d: got %b want %b", cyc, resp_valid, outstanding && armed); end
      vectors++; if (jobs_completed !== model_jobs[15:0]) begin miscompares++; $display("[TB] FAIL rnd_jobs cyc%0d: got %0d want %0d", cyc, jobs_completed, model_jobs); end
      if (outstanding && armed) begin
        vectors++; if (resp_id !== 1'(exp_id_q[0]) || resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_id_err cyc%0d: got %0d/%b want %0d/0", cyc, resp_id, resp_error, exp_id_q[0]); end
        vectors++; if (resp_c !== exp_c_q[0]) begin miscompares++; $display("[TB] FAIL rnd_resp_c cyc%0d: got %h want %h", cyc, resp_c, exp_c_q[0]); end
      end
      if (g >= 0) begin
        outstanding = 1; started = 0; armed = 0;
        exp_id_q.push_back(g);
        exp_c_q.push_back(ref_mul(req_a[g*MW +: MW], req_b[g*MW +: MW]));
      end else if (outstanding) begin
        if (armed && resp_ready) begin
          model_rr = (exp_id_q[0] + 1) % N;
          void'(exp_id_q.pop_front());
          void'(exp_c_q.pop_front());
          model_jobs++;
          outstanding = 0;
        end else begin
          if (started && core_done) armed = 1;
          if (core_start) started = 1;
        end
      end
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    logic [MW-1:0] a, b;
    do_reset();
    a = rand_mat(); b = rand_mat();
    submit(0, a, b, ok);
    wait_resp(ok);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    core_stuck = 1'b1;
    req_valid = '1;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL t5_grant_rr1: got %b want 10", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    #1;
    vectors++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_in_wait: got busy=%b valid=%b want 1/0", busy, resp_valid); end
    tick();
    reset_n_in = 1'b0;
    tick();
    reset_n_in = 1'b1;
    core_stuck = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || core_start !== 1'b0 || core_write_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_idle: got busy=%b start=%b we=%b want 0/0/0", busy, core_start, core_write_enable); end
    vectors++; if (jobs_completed !== 16'd0 || resp_c !== '0 || resp_id !== '0 || resp_error !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_regs: got jobs=%0d c=%h id=%0d err=%b want zeros", jobs_completed, resp_c, resp_id, resp_error); end
    vectors++; if (core_input1 !== '0 || core_input2 !== '0) begin miscompares++; $display("[TB] FAIL t5_core_in: got %h/%h want 0", core_input1, core_input2); end
    for (int t = 0; t < 5; t++) begin
      tick();
      #1;
      vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_no_resp cyc%0d: got %b want 0", t, resp_valid); end
    end
    tick();
    req_valid = '1;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL t5_rr_reset: got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    wait_resp(ok);
    vectors++; if (!ok || resp_id !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_recover: got ok=%b id=%0d want 1/0", ok, resp_id); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

`ifdef TENSOR_CORE_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c;
    do_reset();
    core_stuck = 1'b1;
    submit(0, rand_mat(), rand_mat(), ok);
    c = -1;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (core_start === 1'b1) c = 0;
      else if (c >= 0) c++;
      if (resp_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    vectors++; if (!ok || c != TO + 1) begin miscompares++; $display("[TB] FAIL t6_latency: got ok=%b cycles=%0d want 1/%0d", ok, c, TO + 1); end
    vectors++; if (resp_error !== 1'b1 || resp_c !== '0 || resp_id !== 1'b0) begin miscompares++; $display("[TB] FAIL t6_resp: got err=%b c=%h id=%0d want 1/0/0", resp_error, resp_c, resp_id); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    core_stuck = 1'b0;
    #1;
    vectors++; if (jobs_completed !== 16'd1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL t6_after: got jobs=%0d busy=%b want 1/0", jobs_completed, busy); end
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_identity();
    test_arith();
    test_fairness();
    test_stall();
    test_random();
    test_reset_in_wait();
`ifdef TENSOR_CORE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
